muldiv_hilo_ctrl: RTL
=====================

Name: muldiv_hilo_ctrl

Overview:
Controller that sequences the shared 32-bit iterative divider on behalf of the CPU pipeline. It runs MIPS DIV and DIVU, applies sign conversion before and after the unsigned core, and owns the HI/LO architectural registers, including MTHI and MTLO. It raises a pipeline stall when a new HI/LO operation or an MFHI/MFLO read conflicts with a divide in flight. Pipeline flush abandons a divide without corrupting HI/LO.

Parameters:
WIDTH, 32, operand/HI/LO width; must match the divider core (fixed at 32 in this design)
DIVZERO_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero

Ports:
clock  in  1  system clock; all controller state updates on posedge
reset  in  1  synchronous, active-high reset
op_valid  in  1  HI/LO operation presented this cycle
op  in  3  3'b001 DIV, 3'b010 DIVU, 3'b011 MTHI, 3'b100 MTLO; other codes are no-op
rs_data  in  32  dividend / MTHI / MTLO source
rt_data  in  32  divisor
mf_req  in  1  MFHI/MFLO in decode this cycle
flush  in  1  pipeline flush; abandons any in-flight divide
hi  out  32  HI register
lo  out  32  LO register
stall  out  1  combinational; pipeline must hold the current instruction
div_dividend  out  32  unsigned dividend to the divider core
div_divisor  out  32  unsigned divisor to the divider core
div_start  out  1  divider start, high for exactly one clock
div_busy  in  1  divider busy; the core updates it on negedge clock
div_q  in  32  unsigned quotient from the core
div_r  in  32  unsigned remainder from the core

Behaviour:
- Reset (sync): state=IDLE; hi=0, lo=0, div_start=0, div_dividend=0, div_divisor=0, sign flags=0. Reset mid-divide returns to IDLE immediately. The core is reset by the same reset line.
- States: IDLE, LAUNCH, RUN, FIX, DRAIN.
- Acceptance: an op is accepted at posedge E0 only if state=IDLE, op_valid=1 and flush=0.
- MTHI/MTLO: hi or lo is set to rs_data at E0. State stays IDLE. No stall.
- DIV/DIVU with rt_data!=0:
  - At E0, register div_dividend and div_divisor. For DIVU these are the raw operands. For DIV they are absolute values; abs(0x80000000)=0x80000000 as unsigned.
  - Latch q_neg = rs[31]^rt[31] and r_neg = rs[31] (both forced 0 for DIVU).
  - Go to LAUNCH.
- LAUNCH (1 cycle): div_start=1. Go to RUN at the next edge. The core sees start on the intervening negedge, so div_busy=1 by E1.
- RUN: div_start=0. Stay while div_busy=1. Go to FIX on the first posedge that samples div_busy=0.
- FIX (1 cycle): at its end write lo = q_neg ? -div_q : div_q and hi = r_neg ? -div_r : div_r, both two's complement 32-bit with wrap. Go to IDLE.
- Latency with the 32-iteration core: accept at E0, HI/LO valid after E34. The bench checks this exact edge.
- Divide-by-zero (rt_data==0, DIV or DIVU): no start is issued. At E0 write hi=rs_data and lo=DIVZERO_LO. State stays IDLE. No stall.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- stall = (op_valid && op in {001..100} && state!=IDLE) || (mf_req && state in {LAUNCH, RUN, FIX}).
  - mf_req does not stall in DRAIN, because HI/LO are unchanged there.
  - A stalled op is not accepted; upstream holds op, rs_data and rt_data stable.
- Flush:
  - In LAUNCH or RUN: go to DRAIN; HI/LO unchanged.
  - In FIX: HI/LO write suppressed; go to IDLE.
  - In IDLE: the same-cycle op is dropped.
  - Flush has priority over acceptance.
- DRAIN: wait until div_busy=0, then IDLE. New ops stall throughout so the core is never restarted while busy.
- hi and lo outputs always reflect the registers; there is no bypass of a pending FIX result.

Test Plan:
- Reset: hi=lo=0 and state IDLE. Then DIVU 100/7: lo=14, hi=2 after E34; stall=0 on the accept cycle; stall=1 for mf_req on cycles E1..E34.
- DIV -7/2 (0xFFFFFFF9, 2): lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 5/0: no div_start pulse; hi=5, lo=0xFFFFFFFF at the accept edge.
- MTLO 0x1234 issued at E5 during a divide: stall=1 until IDLE, then lo=0x1234 one edge after the divide completes.
- flush at E10 of DIVU 9/3: HI/LO keep their prior values; stall on a new DIVU until div_busy falls; mf_req not stalled in DRAIN; next DIVU 9/3 gives lo=3, hi=0.
- reset asserted at E20 mid-divide: hi=lo=0, state IDLE, stall=0 on the next edge.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: drives the shared unsigned iterative divider for MIPS DIV/DIVU.
// It converts signs before and after the core and owns the HI/LO registers, including MTHI/MTLO.
// It stalls the pipeline when HI/LO work collides with a divide in flight.
// A flush abandons the divide without touching HI/LO.
module muldiv_hilo_ctrl #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] DIVZERO_LO = 32'hFFFFFFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mf_req,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_start,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_FIX    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] hi_r, hi_s, lo_r, lo_s;
  logic [WIDTH-1:0] dividend_r, dividend_s, divisor_r, divisor_s;
  logic             start_r, start_s;
  logic             q_neg_r, q_neg_s, r_neg_r, r_neg_s;
  logic             hilo_op_s, stall_s;

  // Two's complement negate with wrap (so -0x80000000 stays 0x80000000).
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

  // Magnitude of a signed operand as an unsigned value.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      return twos_neg(x);
    end else begin
      return x;
    end
  endfunction

  // Next-state and next-register computation for the divide sequencer and HI/LO.
  always_comb begin
    state_s    = state_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    dividend_s = dividend_r;
    divisor_s  = divisor_r;
    start_s    = 1'b0;
    q_neg_s    = q_neg_r;
    r_neg_s    = r_neg_r;
    case (state_r)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          case (op)
            OP_DIV, OP_DIVU: begin
              if (rt_data == {WIDTH{1'b0}}) begin
                hi_s = rs_data;
                lo_s = DIVZERO_LO;
              end else begin
                if (op == OP_DIV) begin
                  dividend_s = abs_val(rs_data);
                  divisor_s  = abs_val(rt_data);
                  q_neg_s    = rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                  r_neg_s    = rs_data[WIDTH-1];
                end else begin
                  dividend_s = rs_data;
                  divisor_s  = rt_data;
                  q_neg_s    = 1'b0;
                  r_neg_s    = 1'b0;
                end
                start_s = 1'b1;
                state_s = ST_LAUNCH;
              end
            end
            OP_MTHI: hi_s = rs_data;
            OP_MTLO: lo_s = rs_data;
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (flush) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_s = ST_DRAIN;
        end else if (!div_busy) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIX: begin
        if (!flush) begin
          lo_s = q_neg_r ? twos_neg(div_q) : div_q;
          hi_s = r_neg_r ? twos_neg(div_r) : div_r;
        end else begin
          lo_s = lo_r;
          hi_s = hi_r;
        end
        state_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!div_busy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Hold the pipeline when a HI/LO op or an MF read would race the divide in flight.
  always_comb begin
    stall_s   = 1'b0;
    hilo_op_s = (op >= OP_DIV) && (op <= OP_MTLO);
    if (op_valid && hilo_op_s && (state_r != ST_IDLE)) begin
      stall_s = 1'b1;
    end else if (mf_req && ((state_r == ST_LAUNCH) || (state_r == ST_RUN) || (state_r == ST_FIX))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // HI/LO, divider operand, start and sign-flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      dividend_r <= {WIDTH{1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      start_r    <= 1'b0;
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else begin
      hi_r       <= hi_s;
      lo_r       <= lo_s;
      dividend_r <= dividend_s;
      divisor_r  <= divisor_s;
      start_r    <= start_s;
      q_neg_r    <= q_neg_s;
      r_neg_r    <= r_neg_s;
    end
  end

  assign hi           = hi_r;
  assign lo           = lo_r;
  assign div_dividend = dividend_r;
  assign div_divisor  = divisor_r;
  assign div_start    = start_r;
  assign stall        = stall_s;

endmodule
